// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured W-bit frame MSB first, reps times.
// Optional even-parity bit per frame under `SEQ_TX_PARITY_EN.
module seq_pattern_tx #(
    parameter int W      = 10,
    parameter int REPS_W = 4,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      pattern,
    input  logic [REPS_W-1:0] reps,
    output logic              data,
    output logic              bit_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              done
);

`ifdef SEQ_TX_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif
    localparam int BW = $clog2(W + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0]     LAST  = BW'(FLEN - 1);
    localparam logic [GW-1:0]     GLAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [REPS_W-1:0] ONE   = REPS_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t            state, state_n;
    logic [W-1:0]      shadow, shadow_n;
    logic [W-2:0]      shift_reg, shift_n;
    logic [BW-1:0]     bit_cnt, bit_n;
    logic [REPS_W-1:0] rep_cnt, rep_n;
    logic [GW-1:0]     gap_cnt, gap_n;
    logic              data_n, valid_n, busy_n, fd_n, done_n;
    logic              nxt_bit;

    // shift_reg holds the bits still to go after the one on 'data'
`ifdef SEQ_TX_PARITY_EN
    assign nxt_bit = (bit_cnt == BW'(W - 1)) ? ^shadow
                                             : shift_reg[W-2];
`else
    assign nxt_bit = shift_reg[W-2];
`endif

    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        shift_n  = shift_reg;
        bit_n    = bit_cnt;
        rep_n    = rep_cnt;
        gap_n    = gap_cnt;
        data_n   = 1'b0;
        valid_n  = 1'b0;
        busy_n   = 1'b0;
        fd_n     = 1'b0;
        done_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && reps != '0) begin
                    state_n  = S_SHIFT;
                    shadow_n = pattern;
                    shift_n  = pattern[W-2:0];
                    bit_n    = '0;
                    rep_n    = reps;
                    data_n   = pattern[W-1];
                    valid_n  = 1'b1;
                    busy_n   = 1'b1;
                end
            end
            S_SHIFT: begin
                if (bit_cnt != LAST) begin
                    bit_n   = bit_cnt + BW'(1);
                    shift_n = shift_reg << 1;
                    data_n  = nxt_bit;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    fd_n    = (bit_n == LAST);
                    done_n  = fd_n && (rep_cnt == ONE);
                end else if (rep_cnt != ONE) begin
                    rep_n  = rep_cnt - ONE;
                    busy_n = 1'b1;
                    if (GAP > 0) begin
                        state_n = S_GAP;
                        gap_n   = '0;
                    end else begin
                        shift_n = shadow[W-2:0];
                        bit_n   = '0;
                        data_n  = shadow[W-1];
                        valid_n = 1'b1;
                    end
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_GAP: begin
                busy_n = 1'b1;
                if (gap_cnt == GLAST) begin
                    state_n = S_SHIFT;
                    shift_n = shadow[W-2:0];
                    bit_n   = '0;
                    data_n  = shadow[W-1];
                    valid_n = 1'b1;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            shadow     <= '0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            rep_cnt    <= '0;
            gap_cnt    <= '0;
            data       <= 1'b0;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            shadow     <= shadow_n;
            shift_reg  <= shift_n;
            bit_cnt    <= bit_n;
            rep_cnt    <= rep_n;
            gap_cnt    <= gap_n;
            data       <= data_n;
            bit_valid  <= valid_n;
            busy       <= busy_n;
            frame_done <= fd_n;
            done       <= done_n;
        end
    end

endmodule
